// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared constants and the single-shift helper for the
//                Fibonacci LFSR family. State vectors are numbered [1:W]
//                with q[1] as the MSB and q[W] as the LSB. A tap mask uses
//                the same numbering, so tap position i is numeric bit W-i.
//  Contents    : TAPS_26  - x^26 + x^8 + x^7 + x^1 feedback mask
//                TAPS_4   - x^4 + x^3 feedback mask
//                lfsr_step(state, taps, width) - one Fibonacci shift
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  // Upper bound on register length handled by lfsr_step.
  localparam int unsigned LFSR_MAX_W = 256;

  // Taps at positions 26, 8, 7, 1 -> numeric bits 0, 18, 19, 25.
  localparam logic [1:26] TAPS_26 = 26'h20C_0001;
  // Taps at positions 4, 3 -> numeric bits 0, 1.
  localparam logic [1:4]  TAPS_4  = 4'b0011;

  // One shift on an LSB-aligned, zero-extended state. The state moves one
  // position towards q[width] (a numeric right shift) and the XOR of the
  // tapped bits re-enters at q[1], which sits at numeric bit width-1.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           width
  );
    logic                  fb;
    logic [LFSR_MAX_W-1:0] nxt;
    fb  = ^(state & taps);
    nxt = (state >> 1) | (fb ? (LFSR_MAX_W'(1) << (width - 1)) : '0);
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_gen_next.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen_next
//  Description : Purely combinational next-state cascade: applies STEPS
//                Fibonacci shifts to q_i and presents the final state.
//  Ports       : q_i      [1:WIDTH]  current LFSR state
//                next_q_o [1:WIDTH]  state after STEPS shifts
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen_next
  import lfsr_pkg::*;
#(
  parameter int unsigned    WIDTH = 26,
  parameter logic [1:WIDTH] TAPS  = TAPS_26,
  parameter int unsigned    STEPS = 1
) (
  input  logic [1:WIDTH] q_i,
  output logic [1:WIDTH] next_q_o
);

  localparam logic [LFSR_MAX_W-1:0] c_taps = LFSR_MAX_W'(TAPS);

  // Each stage owns its own output net so the chain is a clean cascade of
  // distinct signals rather than one self-referencing array.
  generate
    for (genvar g = 0; g < STEPS; g++) begin : g_step
      logic [WIDTH-1:0] w_out;
      if (g == 0) begin : g_first
        assign w_out = WIDTH'(lfsr_step(LFSR_MAX_W'(q_i), c_taps, WIDTH));
      end else begin : g_rest
        assign w_out = WIDTH'(lfsr_step(LFSR_MAX_W'(g_step[g-1].w_out),
                                        c_taps, WIDTH));
      end
    end
  endgenerate

  assign next_q_o = g_step[STEPS-1].w_out;

endmodule
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised Fibonacci LFSR PRBS generator with step enable,
//                seed load, seed-return (wrap) detection, zero-state guard
//                and a saturating single-shift counter.
//  Ports       : clk        rising-edge clock
//                rst_ni     synchronous active-low reset
//                en_i       advance STEPS shifts this cycle
//                load_i     synchronous seed load (wins over en_i)
//                din_i      [1:WIDTH] parallel seed
//                q_o        [1:WIDTH] current state (registered)
//                wrap_o     one-cycle pulse: state returned to captured seed
//                zero_fix_o one-cycle pulse: all-zero state/seed was replaced
//                step_cnt_o [CNT_W]   single shifts since last seed, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned    WIDTH = 26,
  parameter logic [1:WIDTH] TAPS  = TAPS_26,
  parameter int unsigned    STEPS = 1,
  parameter logic [1:WIDTH] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned    CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [1:WIDTH]   din_i,
  output logic [1:WIDTH]   q_o,
  output logic             wrap_o,
  output logic             zero_fix_o,
  output logic [CNT_W-1:0] step_cnt_o
);

  // Extra headroom so cnt + STEPS can never overflow before the saturation
  // compare, whatever the relation between CNT_W and STEPS.
  localparam int unsigned c_sum_w = CNT_W + 32;

  logic [1:WIDTH]   q_q,        q_d;
  logic [1:WIDTH]   seed_q,     seed_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             wrap_q,     wrap_d;
  logic             zero_fix_q, zero_fix_d;

  logic [1:WIDTH]     w_next_q;
  logic [c_sum_w-1:0] w_sum;
  logic               w_sat;
  logic               w_din_zero;
  logic               w_q_zero;

  lfsr_gen_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_next (
    .q_i      (q_q),
    .next_q_o (w_next_q)
  );

  assign w_sum      = c_sum_w'(cnt_q) + c_sum_w'(STEPS);
  assign w_sat      = (w_sum > c_sum_w'({CNT_W{1'b1}}));
  assign w_din_zero = (din_i == '0);
  assign w_q_zero   = (q_q == '0);

  always_comb begin
    q_d        = q_q;
    seed_d     = seed_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    zero_fix_d = 1'b0;

    if (load_i) begin
      // An all-zero seed would lock the register, so it is replaced by SEED.
      if (w_din_zero) begin
        q_d        = SEED;
        seed_d     = SEED;
        zero_fix_d = 1'b1;
      end else begin
        q_d    = din_i;
        seed_d = din_i;
      end
      cnt_d = '0;
    end else if (en_i) begin
      if (w_q_zero) begin
        // Lock-up recovery: restart from SEED, counter left untouched.
        q_d        = SEED;
        zero_fix_d = 1'b1;
      end else begin
        q_d    = w_next_q;
        cnt_d  = w_sat ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        // Only the end of the STEPS chain is compared against the seed.
        wrap_d = (w_next_q == seed_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      q_q        <= SEED;
      seed_q     <= SEED;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      zero_fix_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      zero_fix_q <= zero_fix_d;
    end
  end

  assign q_o        = q_q;
  assign wrap_o     = wrap_q;
  assign zero_fix_o = zero_fix_q;
  assign step_cnt_o = cnt_q;

endmodule
`default_nettype wire
